// File: rtl/gayle_xfer_ctrl.sv
// Gayle IDE PIO sector-transfer sequencer: FIFO strobes, DRQ/BSY/IRQ, sector count.
// Optional host watchdog enabled by defining GAYLE_XFER_TIMEOUT_EN.
module gayle_xfer_ctrl #(
    parameter int TIMEOUT_W = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk7_en,
    input  logic       cmd_rd,
    input  logic       cmd_wr,
    input  logic       cmd_abort,
    input  logic [7:0] nsect,
    input  logic       irq_ack,
    input  logic       cpu_dat_rd,
    input  logic       cpu_dat_wr,
    input  logic       host_wr,
    input  logic       host_rd,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    input  logic       fifo_last,
    output logic       fifo_wr,
    output logic       fifo_rd,
    output logic       fifo_clr,
    output logic       host_req,
    output logic       drq,
    output logic       bsy,
    output logic       irq,
    output logic       err,
    output logic [8:0] sect_left
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        R_FILL  = 3'd1,
        R_XFER  = 3'd2,
        W_XFER  = 3'd3,
        W_DRAIN = 3'd4
    } state_t;

    state_t     state_q;
    logic [8:0] sect_q;
    logic [7:0] wcnt_q;
    logic       drq_q, bsy_q, hreq_q, irq_q, err_q, clr_q;
    logic       tmo_hit;
    logic       abort_w;
    logic       unused_fifo_empty;

    assign unused_fifo_empty = fifo_empty;
    assign abort_w = cmd_abort | tmo_hit;

`ifdef GAYLE_XFER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q;

    assign tmo_hit = hreq_q & (&tmo_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (clk7_en) begin
            if (!hreq_q || host_wr || host_rd) tmo_q <= '0;
            else                               tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    logic [31:0] unused_tmo_w;

    assign unused_tmo_w = TIMEOUT_W;
    assign tmo_hit = 1'b0;
`endif

    // An aborting cycle forwards no strobes; the FIFO is flushed anyway.
    assign fifo_wr = clk7_en & ~abort_w &
                     (((state_q == R_FILL) & host_wr) |
                      ((state_q == W_XFER) & cpu_dat_wr));
    assign fifo_rd = clk7_en & ~abort_w &
                     (((state_q == R_XFER) & cpu_dat_rd) |
                      ((state_q == W_DRAIN) & host_rd));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sect_q  <= '0;
            wcnt_q  <= '0;
            drq_q   <= 1'b0;
            bsy_q   <= 1'b0;
            hreq_q  <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else if (clk7_en) begin
            clr_q <= 1'b0;
            if (abort_w) begin
                state_q <= IDLE;
                sect_q  <= '0;
                wcnt_q  <= '0;
                drq_q   <= 1'b0;
                bsy_q   <= 1'b0;
                hreq_q  <= 1'b0;
                clr_q   <= 1'b1;
                if (tmo_hit) err_q <= 1'b1;
            end else begin
                if (irq_ack) irq_q <= 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (cmd_rd && cmd_wr) begin
                            err_q <= 1'b1;
                        end else if (cmd_rd) begin
                            state_q <= R_FILL;
                            sect_q  <= {nsect == 8'd0, nsect};
                            err_q   <= 1'b0;
                            bsy_q   <= 1'b1;
                            hreq_q  <= 1'b1;
                        end else if (cmd_wr) begin
                            state_q <= W_XFER;
                            sect_q  <= {nsect == 8'd0, nsect};
                            err_q   <= 1'b0;
                            wcnt_q  <= '0;
                            drq_q   <= 1'b1;
                        end
                    end
                    R_FILL: begin
                        if (fifo_full) begin
                            state_q <= R_XFER;
                            bsy_q   <= 1'b0;
                            hreq_q  <= 1'b0;
                            drq_q   <= 1'b1;
                            irq_q   <= 1'b1;
                        end
                    end
                    R_XFER: begin
                        if (cpu_dat_rd && fifo_last) begin
                            sect_q <= sect_q - 9'd1;
                            drq_q  <= 1'b0;
                            if (sect_q == 9'd1) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= R_FILL;
                                bsy_q   <= 1'b1;
                                hreq_q  <= 1'b1;
                            end
                        end
                    end
                    W_XFER: begin
                        if (cpu_dat_wr) begin
                            wcnt_q <= wcnt_q + 8'd1;
                            if (wcnt_q == 8'hFF) begin
                                state_q <= W_DRAIN;
                                drq_q   <= 1'b0;
                                bsy_q   <= 1'b1;
                                hreq_q  <= 1'b1;
                            end
                        end
                    end
                    W_DRAIN: begin
                        if (host_rd && fifo_last) begin
                            sect_q <= sect_q - 9'd1;
                            irq_q  <= 1'b1;
                            bsy_q  <= 1'b0;
                            hreq_q <= 1'b0;
                            if (sect_q == 9'd1) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= W_XFER;
                                drq_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                // CPU touching the data register without DRQ is a protocol error.
                if ((cpu_dat_rd || cpu_dat_wr) && !drq_q) err_q <= 1'b1;
            end
        end
    end

    assign drq       = drq_q;
    assign bsy       = bsy_q;
    assign host_req  = hreq_q;
    assign irq       = irq_q;
    assign err       = err_q;
    assign fifo_clr  = clr_q;
    assign sect_left = sect_q;

endmodule

// File: tb/tb_gayle_xfer_ctrl.sv
// Bench for gayle_xfer_ctrl: vector table, hand sequences, random run vs model.
module tb_gayle_xfer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk7_en = 1'b1;
    logic       cmd_rd = 1'b0, cmd_wr = 1'b0, cmd_abort = 1'b0;
    logic [7:0] nsect = 8'd0;
    logic       irq_ack = 1'b0;
    logic       cpu_dat_rd = 1'b0, cpu_dat_wr = 1'b0;
    logic       host_wr = 1'b0, host_rd = 1'b0;
    logic       fifo_full = 1'b0, fifo_empty = 1'b0, fifo_last = 1'b0;
    logic       fifo_wr, fifo_rd, fifo_clr, host_req, drq, bsy, irq, err;
    logic [8:0] sect_left;

    int vec_n = 0;
    int miss_n = 0;

    always #5 clk = ~clk;

    gayle_xfer_ctrl #(.TIMEOUT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en),
        .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_abort(cmd_abort),
        .nsect(nsect), .irq_ack(irq_ack),
        .cpu_dat_rd(cpu_dat_rd), .cpu_dat_wr(cpu_dat_wr),
        .host_wr(host_wr), .host_rd(host_rd),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_last(fifo_last),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_clr(fifo_clr),
        .host_req(host_req), .drq(drq), .bsy(bsy), .irq(irq), .err(err),
        .sect_left(sect_left)
    );

    // {en,crd,cwr,abort, cdr,cdw,hw,hr, full,last,ack}
    typedef struct {
        logic [10:0] in;
        logic [7:0]  ns;
        logic [1:0]  stb;
        logic [5:0]  o;
        logic [8:0]  sect;
    } vec_t;

    vec_t tv[20];

    function automatic logic [15:0] mk(input logic d, input logic b,
                                       input logic h, input logic i,
                                       input logic e, input logic c,
                                       input logic [8:0] s);
        return {1'b0, d, b, h, i, e, c, s};
    endfunction

    function automatic logic [15:0] snap();
        return {1'b0, drq, bsy, host_req, irq, err, fifo_clr, sect_left};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        clk7_en = 1'b1;
        {cmd_rd, cmd_wr, cmd_abort, irq_ack} = '0;
        {cpu_dat_rd, cpu_dat_wr, host_wr, host_rd} = '0;
        {fifo_full, fifo_last} = '0;
        nsect = 8'd0;
    endtask

    task automatic do_reset();
        clr_in();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
    endtask

    // kind: 0 host_wr, 1 cpu_dat_rd, 2 cpu_dat_wr, 3 host_rd
    task automatic burst(input int n, input int kind, input bit last_end,
                         output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       host_wr = 1'b1;
                1:       cpu_dat_rd = 1'b1;
                2:       cpu_dat_wr = 1'b1;
                default: host_rd = 1'b1;
            endcase
            fifo_last = last_end && (i == n - 1);
            #1;
            if (fifo_wr || fifo_rd) cnt++;
            tick();
        end
        {cpu_dat_rd, cpu_dat_wr, host_wr, host_rd, fifo_last} = '0;
    endtask

    // Reference model: transfer described by direction, phase and counts.
    bit m_act, m_rd, m_cpu, m_irq, m_err, m_clr;
    int m_sect, m_words;

    function automatic logic [15:0] m_snap();
        bit cp, hp;
        cp = m_act && m_cpu;
        hp = m_act && !m_cpu;
        return mk(cp, hp, hp, m_irq, m_err, m_clr, 9'(m_sect));
    endfunction

    function automatic logic [15:0] m_stb();
        bit ok, w, r;
        ok = clk7_en && !cmd_abort && m_act;
        w = ok && ((m_rd && !m_cpu && host_wr) || (!m_rd && m_cpu && cpu_dat_wr));
        r = ok && ((m_rd && m_cpu && cpu_dat_rd) || (!m_rd && !m_cpu && host_rd));
        return {14'd0, w, r};
    endfunction

    task automatic model_step();
        bit bad;
        bad = (cpu_dat_rd || cpu_dat_wr) && !(m_act && m_cpu);
        m_clr = 0;
        if (cmd_abort) begin
            m_act = 0;
            m_sect = 0;
            m_words = 0;
            m_clr = 1;
        end else begin
            if (irq_ack) m_irq = 0;
            if (!m_act) begin
                if (cmd_rd && cmd_wr) begin
                    m_err = 1;
                end else if (cmd_rd || cmd_wr) begin
                    m_act = 1;
                    m_rd = cmd_rd;
                    m_cpu = cmd_wr;
                    m_sect = (nsect == 0) ? 256 : int'(nsect);
                    m_words = 0;
                    m_err = 0;
                end
            end else if (m_rd && !m_cpu) begin
                if (fifo_full) begin
                    m_cpu = 1;
                    m_irq = 1;
                end
            end else if (m_rd) begin
                if (cpu_dat_rd && fifo_last) begin
                    m_sect--;
                    if (m_sect == 0) m_act = 0;
                    else m_cpu = 0;
                end
            end else if (m_cpu) begin
                if (cpu_dat_wr) begin
                    m_words++;
                    if (m_words == 256) begin
                        m_words = 0;
                        m_cpu = 0;
                    end
                end
            end else begin
                if (host_rd && fifo_last) begin
                    m_sect--;
                    m_irq = 1;
                    if (m_sect == 0) m_act = 0;
                    else m_cpu = 1;
                end
            end
            if (bad) m_err = 1;
        end
    endtask

    initial begin
        int cnt, n;

        tv[0]  = '{11'b1000_1000_000, 8'd0, 2'b00, 6'b000010, 9'd0};
        tv[1]  = '{11'b1110_0000_000, 8'd5, 2'b00, 6'b000010, 9'd0};
        tv[2]  = '{11'b1010_0000_000, 8'd3, 2'b00, 6'b100000, 9'd3};
        tv[3]  = '{11'b1000_0100_000, 8'd0, 2'b10, 6'b100000, 9'd3};
        tv[4]  = '{11'b1000_0001_010, 8'd0, 2'b00, 6'b100000, 9'd3};
        tv[5]  = '{11'b1100_0000_000, 8'd7, 2'b00, 6'b100000, 9'd3};
        tv[6]  = '{11'b1001_0100_000, 8'd0, 2'b00, 6'b000001, 9'd0};
        tv[7]  = '{11'b1000_0000_000, 8'd0, 2'b00, 6'b000000, 9'd0};
        tv[8]  = '{11'b1100_0000_000, 8'd0, 2'b00, 6'b011000, 9'd256};
        tv[9]  = '{11'b1000_0010_000, 8'd0, 2'b10, 6'b011000, 9'd256};
        tv[10] = '{11'b1000_0100_000, 8'd0, 2'b00, 6'b011010, 9'd256};
        tv[11] = '{11'b1000_0000_100, 8'd0, 2'b00, 6'b100110, 9'd256};
        tv[12] = '{11'b1000_0010_001, 8'd0, 2'b00, 6'b100010, 9'd256};
        tv[13] = '{11'b1000_1000_000, 8'd0, 2'b01, 6'b100010, 9'd256};
        tv[14] = '{11'b1000_1000_010, 8'd0, 2'b01, 6'b011010, 9'd255};
        tv[15] = '{11'b0000_0010_100, 8'd0, 2'b00, 6'b011010, 9'd255};
        tv[16] = '{11'b1000_0000_101, 8'd0, 2'b00, 6'b100110, 9'd255};
        tv[17] = '{11'b1001_0000_000, 8'd0, 2'b00, 6'b000111, 9'd0};
        tv[18] = '{11'b0000_0000_000, 8'd0, 2'b00, 6'b000111, 9'd0};
        tv[19] = '{11'b1010_0000_000, 8'd1, 2'b00, 6'b100100, 9'd1};

        do_reset();
        chk("reset outs", snap(), mk(0, 0, 0, 0, 0, 0, 9'd0));
        chk("reset strobes", 16'({fifo_wr, fifo_rd}), 16'd0);

        for (int i = 0; i < 20; i++) begin
            {clk7_en, cmd_rd, cmd_wr, cmd_abort,
             cpu_dat_rd, cpu_dat_wr, host_wr, host_rd,
             fifo_full, fifo_last, irq_ack} = tv[i].in;
            nsect = tv[i].ns;
            #1;
            chk($sformatf("vec%0d strobes", i), 16'({fifo_wr, fifo_rd}),
                16'(tv[i].stb));
            tick();
            chk($sformatf("vec%0d outs", i), snap(),
                {1'b0, tv[i].o, tv[i].sect});
        end
        clr_in();

        // One-sector read
        do_reset();
        nsect = 8'd1; cmd_rd = 1'b1; tick(); clr_in();
        chk("rd1 fill", snap(), mk(0, 1, 1, 0, 0, 0, 9'd1));
        burst(256, 0, 0, cnt);
        chk("rd1 host writes", 16'(cnt), 16'd256);
        fifo_full = 1'b1; tick(); fifo_full = 1'b0;
        chk("rd1 drq", snap(), mk(1, 0, 0, 1, 0, 0, 9'd1));
        burst(255, 1, 0, cnt);
        chk("rd1 mid", snap(), mk(1, 0, 0, 1, 0, 0, 9'd1));
        burst(1, 1, 1, n);
        chk("rd1 cpu reads", 16'(cnt + n), 16'd256);
        chk("rd1 done", snap(), mk(0, 0, 0, 1, 0, 0, 9'd0));

        // Two-sector write
        do_reset();
        nsect = 8'd2; cmd_wr = 1'b1; tick(); clr_in();
        chk("wr2 start", snap(), mk(1, 0, 0, 0, 0, 0, 9'd2));
        burst(256, 2, 0, cnt);
        chk("wr2 cpu writes", 16'(cnt), 16'd256);
        chk("wr2 drain", snap(), mk(0, 1, 1, 0, 0, 0, 9'd2));
        burst(256, 3, 1, cnt);
        chk("wr2 host reads", 16'(cnt), 16'd256);
        chk("wr2 sector1", snap(), mk(1, 0, 0, 1, 0, 0, 9'd1));
        burst(256, 2, 0, cnt);
        chk("wr2 drain2", snap(), mk(0, 1, 1, 1, 0, 0, 9'd1));
        burst(256, 3, 1, cnt);
        chk("wr2 done", snap(), mk(0, 0, 0, 1, 0, 0, 9'd0));

        // 256-sector read aborted in its third sector
        do_reset();
        nsect = 8'd0; cmd_rd = 1'b1; tick(); clr_in();
        chk("rd256 start", snap(), mk(0, 1, 1, 0, 0, 0, 9'd256));
        for (int s = 0; s < 2; s++) begin
            fifo_full = 1'b1; tick(); fifo_full = 1'b0;
            burst(256, 1, 1, cnt);
        end
        chk("rd256 two done", snap(), mk(0, 1, 1, 1, 0, 0, 9'd254));
        fifo_full = 1'b1; tick(); fifo_full = 1'b0;
        burst(10, 1, 0, cnt);
        chk("rd256 third", snap(), mk(1, 0, 0, 1, 0, 0, 9'd254));
        cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
        chk("abort", snap(), mk(0, 0, 0, 1, 0, 1, 9'd0));
        tick();
        chk("abort clr drop", snap(), mk(0, 0, 0, 1, 0, 0, 9'd0));

        // Asynchronous reset in the middle of a write sector
        do_reset();
        nsect = 8'd4; cmd_wr = 1'b1; tick(); clr_in();
        burst(100, 2, 0, cnt);
        chk("wr100", snap(), mk(1, 0, 0, 0, 0, 0, 9'd4));
        cpu_dat_wr = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("async reset outs", snap(), mk(0, 0, 0, 0, 0, 0, 9'd0));
        chk("async reset strobes", 16'({fifo_wr, fifo_rd}), 16'd0);
        cpu_dat_wr = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        nsect = 8'd1; cmd_wr = 1'b1; tick(); clr_in();
        burst(255, 2, 0, cnt);
        chk("restart 255", snap(), mk(1, 0, 0, 0, 0, 0, 9'd1));
        burst(1, 2, 0, cnt);
        chk("restart 256", snap(), mk(0, 1, 1, 0, 0, 0, 9'd1));

`ifdef GAYLE_XFER_TIMEOUT_EN
        // Counter reaches all-ones 15 edges after host_req rises; abort lands on the next.
        do_reset();
        nsect = 8'd1; cmd_rd = 1'b1; tick(); clr_in();
        n = 0;
        while (!fifo_clr && n < 40) begin
            tick();
            n++;
        end
        chk("timeout cycles", 16'(n), 16'd16);
        chk("timeout outs", snap(), mk(0, 0, 0, 0, 1, 1, 9'd0));
`else
        // Random traffic against the reference model
        do_reset();
        {m_act, m_rd, m_cpu, m_irq, m_err, m_clr} = '0;
        m_sect = 0;
        m_words = 0;
        for (int c = 0; c < 4000; c++) begin
            clk7_en    = ($urandom % 4) != 0;
            cmd_rd     = ($urandom % 16) == 0;
            cmd_wr     = ($urandom % 16) == 0;
            cmd_abort  = ($urandom % 1024) == 0;
            nsect      = 8'(1 + $urandom % 3);
            irq_ack    = ($urandom % 8) == 0;
            cpu_dat_rd = ($urandom % 2) == 0;
            cpu_dat_wr = ($urandom % 2) == 0;
            host_wr    = ($urandom % 2) == 0;
            host_rd    = ($urandom % 2) == 0;
            fifo_full  = ($urandom % 3) == 0;
            fifo_last  = ($urandom % 4) == 0;
            if (cmd_rd || cmd_wr) {cpu_dat_rd, cpu_dat_wr} = '0;
            if (cmd_abort) irq_ack = 1'b0;
            #1;
            chk("rand strobes", 16'({fifo_wr, fifo_rd}), m_stb());
            @(posedge clk);
            if (clk7_en) model_step();
            #1;
            chk("rand outs", snap(), m_snap());
        end
        clr_in();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
